// File: rtl/lm32_cmp_stage.sv
// Registered compare/flag stage behind lm32_addsub: evaluates cmp_op on the subtractor result.
// Optional build macro LM32_CMP_SKID_EN selects a 2-entry skid buffer instead of a single register.
module lm32_cmp_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] diff_i,
  input  logic             cout_i,
  input  logic             a_msb_i,
  input  logic             b_msb_i,
  input  logic [2:0]       cmp_op_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff_o,
  output logic             cond_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             ovf_o
);

  localparam logic [2:0] OP_EQ  = 3'd0;
  localparam logic [2:0] OP_NE  = 3'd1;
  localparam logic [2:0] OP_GT  = 3'd2;
  localparam logic [2:0] OP_GE  = 3'd3;
  localparam logic [2:0] OP_GTU = 3'd4;
  localparam logic [2:0] OP_GEU = 3'd5;

  localparam int unsigned E_W = WIDTH + TAG_W + 2;

  logic           eq;
  logic           ovf;
  logic           lt;
  logic           cond;
  logic           in_fire;
  logic [E_W-1:0] in_entry;
  logic [E_W-1:0] main_q;

  // Signed compare derived from the difference sign corrected by overflow.
  always_comb begin
    eq  = (diff_i == '0);
    ovf = (a_msb_i != b_msb_i) & (diff_i[WIDTH-1] != a_msb_i);
    lt  = diff_i[WIDTH-1] ^ ovf;
    case (cmp_op_i)
      OP_EQ:   cond = eq;
      OP_NE:   cond = ~eq;
      OP_GT:   cond = ~lt & ~eq;
      OP_GE:   cond = ~lt;
      OP_GTU:  cond = cout_i & ~eq;
      OP_GEU:  cond = cout_i;
      default: cond = 1'b0;
    endcase
  end

  assign in_entry = {diff_i, cond, ovf, tag_i};
  assign in_fire  = in_valid & in_ready;
  assign {diff_o, cond_o, ovf_o, tag_o} = main_q;

`ifdef LM32_CMP_SKID_EN
  logic [E_W-1:0] skid_q;
  logic           skid_valid;

  assign in_ready = ~skid_valid;

  // A word arriving while the output is stalled parks in skid; skid refills main before new input.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_q     <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (out_ready) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid || out_ready) begin
        main_q    <= in_entry;
        out_valid <= 1'b1;
      end else begin
        skid_q     <= in_entry;
        skid_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_q    <= '0;
      out_valid <= 1'b0;
    end else if (in_fire) begin
      main_q    <= in_entry;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_lm32_cmp_stage.sv
// Scoreboard bench for lm32_cmp_stage: directed compare cases, stalled stream, mid-flight reset.
module tb_lm32_cmp_stage;

  typedef struct packed {
    logic [31:0] diff;
    logic        cond;
    logic        ovf;
    logic [4:0]  tag;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] diff_i;
  logic        cout_i;
  logic        a_msb_i;
  logic        b_msb_i;
  logic [2:0]  cmp_op_i;
  logic [4:0]  tag_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff_o;
  logic        cond_o;
  logic [4:0]  tag_o;
  logic        ovf_o;

  ent_t q[$];
  ent_t cur_exp;
  ent_t prev_out;
  ent_t got;
  bit   accepted;
  bit   prev_stall;
  int   n_checks = 0;
  int   n_bad = 0;
  int   idx;
  int   cyc;

  always #5 clk = ~clk;

  lm32_cmp_stage #(.WIDTH(32), .TAG_W(5)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .in_valid(in_valid), .in_ready(in_ready),
    .diff_i(diff_i), .cout_i(cout_i), .a_msb_i(a_msb_i), .b_msb_i(b_msb_i),
    .cmp_op_i(cmp_op_i), .tag_i(tag_i), .out_valid(out_valid), .out_ready(out_ready),
    .diff_o(diff_o), .cond_o(cond_o), .tag_o(tag_o), .ovf_o(ovf_o)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic ent_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic [4:0] tag);
    ent_t e;
    logic [32:0] wide;
    wide   = {a[31], a} - {b[31], b};
    e.diff = a - b;
    e.ovf  = wide[32] ^ wide[31];
    e.tag  = tag;
    case (op)
      3'd0:    e.cond = (a == b);
      3'd1:    e.cond = (a != b);
      3'd2:    e.cond = ($signed(a) > $signed(b));
      3'd3:    e.cond = ($signed(a) >= $signed(b));
      3'd4:    e.cond = (a > b);
      3'd5:    e.cond = (a >= b);
      default: e.cond = 1'b0;
    endcase
    return e;
  endfunction

  task automatic set_in(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [4:0] tag);
    diff_i   = a - b;
    cout_i   = (a >= b);
    a_msb_i  = a[31];
    b_msb_i  = b[31];
    cmp_op_i = op;
    tag_i    = tag;
    cur_exp  = model(a, b, op, tag);
  endtask

  // Inputs are driven at posedge+1, sampled at negedge, captured at the next posedge.
  task automatic cycle();
    @(negedge clk);
    accepted = 1'b0;
    if (rst_n_i) begin
`ifdef LM32_CMP_SKID_EN
      check("in_ready", in_ready, (q.size() < 2));
`else
      check("in_ready", in_ready, (q.size() == 0) || out_ready);
`endif
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_fields", {diff_o, cond_o, ovf_o, tag_o}, prev_out);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", out_valid, 0);
        else begin
          got = {diff_o, cond_o, ovf_o, tag_o};
          check("out_entry", got, q.pop_front());
        end
      end
      accepted = in_valid && in_ready;
      if (accepted) q.push_back(cur_exp);
      prev_stall = out_valid && !out_ready;
      prev_out   = {diff_o, cond_o, ovf_o, tag_o};
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [4:0] tag);
    int n;
    set_in(a, b, op, tag);
    in_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 20);
    if (!accepted) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
    cycle();
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    rst_n_i    = 1'b0;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    prev_stall = 1'b0;
    set_in(32'd9, 32'd3, 3'd2, 5'd7);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fields", {diff_o, cond_o, ovf_o, tag_o}, 0);
    rst_n_i   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    send(32'd5, 32'd5, 3'd0, 5'd1);
    send(32'd5, 32'd5, 3'd4, 5'd2);
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'd2, 5'd3);
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'd4, 5'd4);
    send(32'd1, 32'd2, 3'd5, 5'd5);
    send(32'd1, 32'd2, 3'd1, 5'h1F);
    send(32'h8000_0000, 32'd1, 3'd3, 5'd6);
    send(32'd3, 32'd9, 3'd6, 5'd8);
    send(32'd9, 32'd3, 3'd7, 5'd9);
    drain();

    // Back-to-back stream with downstream stalled on cycles 3-5.
    idx = 1;
    cyc = 0;
    while ((idx <= 8 || q.size() > 0) && cyc < 60) begin
      cyc++;
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (idx <= 8) begin
        set_in(32'(idx * 7), 32'(idx * idx), 3'(idx % 8), 5'(idx));
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      cycle();
      if (accepted) idx++;
    end
    check("stream_all_in", idx, 9);
    check("stream_all_out", q.size(), 0);
    in_valid = 1'b0;

    // Reset with entries held downstream-stalled.
    out_ready = 1'b0;
    send(32'd11, 32'd4, 3'd2, 5'd20);
`ifdef LM32_CMP_SKID_EN
    send(32'd12, 32'd4, 3'd3, 5'd21);
`endif
    rst_n_i = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_fields", {diff_o, cond_o, ovf_o, tag_o}, 0);
    q.delete();
    prev_stall = 1'b0;
    set_in(32'd1, 32'd1, 3'd0, 5'd22);
    in_valid = 1'b1;
    cycle();
    rst_n_i   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    send(32'hFFFF_FFFF, 32'd0, 3'd5, 5'd10);
    drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
